// File: rtl/top_level_types.sv
// top_level_types: payload formats shared by the control unit, the loaders and Memory.
package top_level_types;

    // Request from a master to Memory.
    typedef struct packed {
        logic [31:0] addrIn;
        logic [31:0] dataIn;
        logic [3:0]  mask;
        logic        req;      // 1 = write, 0 = read
    } CUtoME_IF;

    // Response from Memory back to a master.
    typedef struct packed {
        logic [31:0] loadedData;
    } MEtoCU_IF;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Memory request/response channel pair between
// requester 0 (CPU control unit) and requester 1 (loader/debug master).
// Whole transactions are serialised: accept one request, issue it to Memory,
// collect the single response, return it to the owner, then re-arbitrate.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin grant;
// when it is undefined requester 0 has fixed priority.
module mem_port_arbiter
    import top_level_types::*;
(
    input  logic     clk,
    input  logic     rst,

    input  CUtoME_IF req0_port,
    input  logic     req0_port_notify,
    output logic     req0_port_sync,
    input  CUtoME_IF req1_port,
    input  logic     req1_port_notify,
    output logic     req1_port_sync,

    output MEtoCU_IF rsp0_port,
    output logic     rsp0_port_notify,
    input  logic     rsp0_port_sync,
    output MEtoCU_IF rsp1_port,
    output logic     rsp1_port_notify,
    input  logic     rsp1_port_sync,

    output CUtoME_IF CtlToMem_port,
    output logic     CtlToMem_port_notify,
    input  logic     CtlToMem_port_sync,

    input  MEtoCU_IF MemToCtl_port,
    input  logic     MemToCtl_port_notify,
    output logic     MemToCtl_port_sync,

    output logic     grant,
    output logic     busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ACCEPT    = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_RETURN    = 3'd4;

    logic [2:0] state_q, state_d;
    logic       grant_q, grant_d;
    CUtoME_IF   req_buf_q, req_buf_d;
    MEtoCU_IF   rsp_buf_q, rsp_buf_d;
    MEtoCU_IF   rsp0_port_q, rsp0_port_d;
    MEtoCU_IF   rsp1_port_q, rsp1_port_d;

    // Owner chosen for the next transaction if arbitration happens this cycle
    logic       pick;
    // Request channel and response-ready of the current owner
    logic       owner_notify;
    CUtoME_IF   owner_payload;
    logic       owner_rsp_sync;

    // Select the winner among the requesters currently asserting notify
    always_comb begin
        pick = 1'b0;
        if (req0_port_notify && req1_port_notify) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Contention: hand the channel to whoever did not own it last.
            pick = ~grant_q;
`else
            // Contention: requester 0 always wins.
            pick = 1'b0;
`endif
        end else if (req1_port_notify) begin
            pick = 1'b1;
        end
    end

    // Route the owner's channels so the FSM only looks at one side
    always_comb begin
        owner_notify   = grant_q ? req1_port_notify : req0_port_notify;
        owner_payload  = grant_q ? req1_port        : req0_port;
        owner_rsp_sync = grant_q ? rsp1_port_sync   : rsp0_port_sync;
    end

    // Transaction sequencing and payload capture
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_buf_d   = req_buf_q;
        rsp_buf_d   = rsp_buf_q;
        rsp0_port_d = rsp0_port_q;
        rsp1_port_d = rsp1_port_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_port_notify || req1_port_notify) begin
                    grant_d = pick;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                // A requester that withdraws notify here simply keeps us waiting.
                if (owner_notify) begin
                    req_buf_d = owner_payload;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (CtlToMem_port_sync) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (MemToCtl_port_notify) begin
                    rsp_buf_d = MemToCtl_port;
                    // Load only the owner's response register so the other
                    // requester's port keeps its last value.
                    if (grant_q) begin
                        rsp1_port_d = MemToCtl_port;
                    end else begin
                        rsp0_port_d = MemToCtl_port;
                    end
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (owner_rsp_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and payload registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b1;
            req_buf_q   <= '0;
            rsp_buf_q   <= '0;
            rsp0_port_q <= '0;
            rsp1_port_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_buf_q   <= req_buf_d;
            rsp_buf_q   <= rsp_buf_d;
            rsp0_port_q <= rsp0_port_d;
            rsp1_port_q <= rsp1_port_d;
        end
    end

    // Handshake outputs decoded from state and owner only, never from inputs
    always_comb begin
        req0_port_sync       = (state_q == ST_ACCEPT)    && !grant_q;
        req1_port_sync       = (state_q == ST_ACCEPT)    &&  grant_q;
        CtlToMem_port_notify = (state_q == ST_ISSUE);
        MemToCtl_port_sync   = (state_q == ST_WAIT_RESP);
        rsp0_port_notify     = (state_q == ST_RETURN)    && !grant_q;
        rsp1_port_notify     = (state_q == ST_RETURN)    &&  grant_q;
        busy                 = (state_q != ST_IDLE);
        grant                = grant_q;
        CtlToMem_port        = req_buf_q;
        rsp0_port            = rsp0_port_q;
        rsp1_port            = rsp1_port_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Requesters and a Memory stub are modelled at transaction level; expected
// results come from per-requester reference memories and a grant-order model.
module tb_mem_port_arbiter;
    import top_level_types::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    CUtoME_IF req0_port = '0;
    CUtoME_IF req1_port = '0;
    logic     req0_port_notify = 1'b0, req1_port_notify = 1'b0;
    logic     req0_port_sync, req1_port_sync;
    MEtoCU_IF rsp0_port, rsp1_port;
    logic     rsp0_port_notify, rsp1_port_notify;
    logic     rsp0_port_sync = 1'b0, rsp1_port_sync = 1'b0;
    CUtoME_IF CtlToMem_port;
    logic     CtlToMem_port_notify;
    logic     CtlToMem_port_sync = 1'b0;
    MEtoCU_IF MemToCtl_port = '0;
    logic     MemToCtl_port_notify = 1'b0;
    logic     MemToCtl_port_sync;
    logic     grant, busy;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_port(req0_port), .req0_port_notify(req0_port_notify), .req0_port_sync(req0_port_sync),
        .req1_port(req1_port), .req1_port_notify(req1_port_notify), .req1_port_sync(req1_port_sync),
        .rsp0_port(rsp0_port), .rsp0_port_notify(rsp0_port_notify), .rsp0_port_sync(rsp0_port_sync),
        .rsp1_port(rsp1_port), .rsp1_port_notify(rsp1_port_notify), .rsp1_port_sync(rsp1_port_sync),
        .CtlToMem_port(CtlToMem_port), .CtlToMem_port_notify(CtlToMem_port_notify),
        .CtlToMem_port_sync(CtlToMem_port_sync),
        .MemToCtl_port(MemToCtl_port), .MemToCtl_port_notify(MemToCtl_port_notify),
        .MemToCtl_port_sync(MemToCtl_port_sync),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Environment state shared between the tests and the environment process
    CUtoME_IF    rq0[$], rq1[$];
    MEtoCU_IF    pend[$];
    CUtoME_IF    mem_log[$];
    logic [31:0] got0[$], got1[$];
    int          grant_log[$];
    logic [31:0] mem_arr [64];
    int          rsp_stall0 = 0, rsp_stall1 = 0;
    int          mem_acc_stall = 0, mem_rsp_stall = 0;
    bit          rand_mode = 1'b0;
    int          busy_cycles = 0, rsp1_seen = 0, rsp0_at = -1, mem_at_rsp1 = -1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic logic [31:0] patt(int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Reference policy: who wins given which requesters are pending and the last owner
    function automatic int next_winner(bit w0, bit w1, int last);
        if (w0 && w1) return RR ? (1 - last) : 0;
        return w0 ? 0 : 1;
    endfunction

    // Environment: requesters and Memory stub act on the falling edge.
    // A transfer happens at the next rising edge when our new drive meets the
    // arbiter's current (state-decoded) handshake output.
    initial begin : env
        CUtoME_IF prev_ctl;
        MEtoCU_IF prev_r0, prev_r1;
        bit hold_ctl, hold_r0, hold_r1;
        int nhs;
        hold_ctl = 0; hold_r0 = 0; hold_r1 = 0;
        prev_ctl = '0; prev_r0 = '0; prev_r1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_ctl = 0; hold_r0 = 0; hold_r1 = 0;
            end else begin
                nhs = $countones({req0_port_sync, req1_port_sync, CtlToMem_port_notify,
                                  MemToCtl_port_sync, rsp0_port_notify, rsp1_port_notify});
                checks++;
                if (nhs > 1) begin
                    errors++;
                    $display("FAIL handshake_onehot: %0d arbiter handshakes high, at most 1 allowed", nhs);
                end
                if (hold_ctl) begin
                    checks++;
                    if (!CtlToMem_port_notify || CtlToMem_port !== prev_ctl) begin
                        errors++;
                        $display("FAIL ctl_stable: notify=%b port=%h expected notify=1 port=%h",
                                 CtlToMem_port_notify, CtlToMem_port, prev_ctl);
                    end
                end
                if (hold_r0) begin
                    checks++;
                    if (!rsp0_port_notify || rsp0_port !== prev_r0) begin
                        errors++;
                        $display("FAIL rsp0_stable: notify=%b port=%h expected notify=1 port=%h",
                                 rsp0_port_notify, rsp0_port, prev_r0);
                    end
                end
                if (hold_r1) begin
                    checks++;
                    if (!rsp1_port_notify || rsp1_port !== prev_r1) begin
                        errors++;
                        $display("FAIL rsp1_stable: notify=%b port=%h expected notify=1 port=%h",
                                 rsp1_port_notify, rsp1_port, prev_r1);
                    end
                end
                if (busy) busy_cycles++;
                if (rsp1_port_notify) rsp1_seen++;
                if (rsp0_port_notify && rsp0_at < 0) rsp0_at = busy_cycles;
            end

            // Requesters present queued requests continuously
            req0_port_notify = (rq0.size() > 0);
            if (rq0.size() > 0) req0_port = rq0[0];
            if (req0_port_notify && req0_port_sync) begin
                grant_log.push_back(0);
                void'(rq0.pop_front());
            end
            req1_port_notify = (rq1.size() > 0);
            if (rq1.size() > 0) req1_port = rq1[0];
            if (req1_port_notify && req1_port_sync) begin
                grant_log.push_back(1);
                void'(rq1.pop_front());
            end

            // Requesters accept responses, optionally stalling
            rsp0_port_sync = 1'b1;
            if (rand_mode) rsp0_port_sync = ($urandom_range(0, 1) == 1);
            else if (rsp0_port_notify && rsp_stall0 > 0) begin
                rsp0_port_sync = 1'b0;
                rsp_stall0--;
            end
            if (rsp0_port_notify && rsp0_port_sync) begin
                got0.push_back(rsp0_port.loadedData);
                $display("txn rsp0 data=%h", rsp0_port.loadedData);
            end
            rsp1_port_sync = 1'b1;
            if (rand_mode) rsp1_port_sync = ($urandom_range(0, 1) == 1);
            else if (rsp1_port_notify && rsp_stall1 > 0) begin
                rsp1_port_sync = 1'b0;
                rsp_stall1--;
            end
            if (rsp1_port_notify && rsp1_port_sync) begin
                got1.push_back(rsp1_port.loadedData);
                mem_at_rsp1 = mem_log.size();
                $display("txn rsp1 data=%h", rsp1_port.loadedData);
            end

            // Memory stub response side (before accept, so no same-cycle reply)
            MemToCtl_port_notify = 1'b0;
            if (pend.size() > 0) begin
                if (mem_rsp_stall > 0) mem_rsp_stall--;
                else if (!rand_mode || $urandom_range(0, 1) == 1) begin
                    MemToCtl_port_notify = 1'b1;
                    MemToCtl_port = pend[0];
                end
            end
            if (MemToCtl_port_notify && MemToCtl_port_sync) void'(pend.pop_front());

            // Memory stub request side: reads return the word, writes store and echo
            CtlToMem_port_sync = 1'b1;
            if (rand_mode) CtlToMem_port_sync = ($urandom_range(0, 1) == 1);
            else if (CtlToMem_port_notify && mem_acc_stall > 0) begin
                CtlToMem_port_sync = 1'b0;
                mem_acc_stall--;
            end
            if (CtlToMem_port_notify && CtlToMem_port_sync) begin
                MEtoCU_IF r;
                mem_log.push_back(CtlToMem_port);
                if (CtlToMem_port.req) begin
                    mem_arr[CtlToMem_port.addrIn[7:2]] = CtlToMem_port.dataIn;
                    r.loadedData = CtlToMem_port.dataIn;
                end else begin
                    r.loadedData = mem_arr[CtlToMem_port.addrIn[7:2]];
                end
                pend.push_back(r);
            end

            hold_ctl = CtlToMem_port_notify && !CtlToMem_port_sync;
            hold_r0  = rsp0_port_notify && !rsp0_port_sync;
            hold_r1  = rsp1_port_notify && !rsp1_port_sync;
            prev_ctl = CtlToMem_port;
            prev_r0  = rsp0_port;
            prev_r1  = rsp1_port;
        end
    end

    task automatic clear_env();
        rq0.delete(); rq1.delete(); pend.delete(); mem_log.delete();
        got0.delete(); got1.delete(); grant_log.delete();
        rsp_stall0 = 0; rsp_stall1 = 0; mem_acc_stall = 0; mem_rsp_stall = 0;
        rand_mode = 1'b0;
        busy_cycles = 0; rsp1_seen = 0; rsp0_at = -1; mem_at_rsp1 = -1;
        for (int i = 0; i < 64; i++) mem_arr[i] = patt(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_env();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(rq0.size() == 0 && rq1.size() == 0 && pend.size() == 0 && !busy) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required completion", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: busy=%b grant=%b required busy=0 grant=1", busy, grant);
        end
        checks++;
        if ({req0_port_sync, req1_port_sync, CtlToMem_port_notify, MemToCtl_port_sync,
             rsp0_port_notify, rsp1_port_notify} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: %b required 000000", {req0_port_sync, req1_port_sync,
                     CtlToMem_port_notify, MemToCtl_port_sync, rsp0_port_notify, rsp1_port_notify});
        end
        checks++;
        if (CtlToMem_port !== '0 || rsp0_port !== '0 || rsp1_port !== '0) begin
            errors++;
            $display("FAIL reset_ports: ctl=%h rsp0=%h rsp1=%h required all zero",
                     CtlToMem_port, rsp0_port, rsp1_port);
        end
        clear_env();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        CUtoME_IF p;
        do_reset();
        mem_arr[4] = 32'h0010_0073;
        p.addrIn = 32'h0000_0010; p.dataIn = '0; p.mask = 4'hF; p.req = 1'b0;
        rq0.push_back(p);
        wait_idle(100, "single_read");
        checks++;
        if (mem_log.size() != 1 || mem_log[0] !== p) begin
            errors++;
            $display("FAIL single_mem_payload: count=%0d required 1 with payload %h", mem_log.size(), p);
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== 32'h0010_0073) begin
            errors++;
            $display("FAIL single_rsp0: count=%0d data=%h required 1 x 00100073",
                     got0.size(), (got0.size() > 0) ? got0[0] : 32'h0);
        end
        checks++;
        if (rsp0_at != 4) begin
            errors++;
            $display("FAIL single_rsp_cycle: rsp0 notify at cycle %0d required 4", rsp0_at);
        end
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("FAIL single_busy_len: busy for %0d cycles required 4 (falls at cycle 5)", busy_cycles);
        end
        checks++;
        if (rsp1_seen != 0) begin
            errors++;
            $display("FAIL single_rsp1_quiet: rsp1 notify seen %0d cycles required 0", rsp1_seen);
        end
    endtask

    task automatic test_contention();
        CUtoME_IF p;
        int exp_order[$];
        int last, c0, c1, w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p.addrIn = 32'(i * 4);        p.dataIn = '0; p.mask = 4'hF; p.req = 1'b0;
            rq0.push_back(p);
            p.addrIn = 32'((32 + i) * 4);
            rq1.push_back(p);
        end
        last = 1; c0 = 0; c1 = 0;
        while (c0 < 4 || c1 < 4) begin
            w = next_winner(c0 < 4, c1 < 4, last);
            exp_order.push_back(w);
            last = w;
            if (w == 0) c0++; else c1++;
        end
        wait_idle(200, "contention");
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL contention_count: %0d grants required 8", grant_log.size());
        end
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != exp_order[k]) begin
                errors++;
                $display("FAIL contention_order[%0d]: grant %0d required %0d", k, grant_log[k], exp_order[k]);
            end
        end
        checks++;
        if (got0.size() != 4 || got1.size() != 4) begin
            errors++;
            $display("FAIL contention_rsp_count: rsp0=%0d rsp1=%0d required 4 and 4", got0.size(), got1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got0[i] !== patt(i) || got1[i] !== patt(32 + i)) begin
                    errors++;
                    $display("FAIL contention_data[%0d]: rsp0=%h rsp1=%h required %h %h",
                             i, got0[i], got1[i], patt(i), patt(32 + i));
                end
            end
        end
    endtask

    task automatic test_stalls();
        CUtoME_IF p;
        do_reset();
        mem_arr[8] = 32'h1357_9BDF;
        mem_acc_stall = 3;
        rsp_stall0 = 2;
        p.addrIn = 32'h0000_0020; p.dataIn = '0; p.mask = 4'hF; p.req = 1'b0;
        rq0.push_back(p);
        wait_idle(100, "stalls");
        checks++;
        if (busy_cycles != 9) begin
            errors++;
            $display("FAIL stall_length: busy %0d cycles required 9 (10-cycle transaction)", busy_cycles);
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL stall_rsp0: count=%0d data=%h required 1 x 13579bdf",
                     got0.size(), (got0.size() > 0) ? got0[0] : 32'h0);
        end
    endtask

    task automatic test_write_req1();
        CUtoME_IF w, r;
        int n;
        do_reset();
        rsp_stall1 = 3;
        w.addrIn = 32'h0000_0040; w.dataIn = 32'hDEAD_BEEF; w.mask = 4'hF; w.req = 1'b1;
        rq1.push_back(w);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp1_port_notify && n < 50);
        checks++;
        if (!rsp1_port_notify) begin
            errors++;
            $display("FAIL write_rsp1_timeout: no rsp1 notify after %0d cycles, required one", n);
        end
        // A competing read arrives while the write's response is still stalled
        r.addrIn = 32'h0000_0010; r.dataIn = '0; r.mask = 4'hF; r.req = 1'b0;
        rq0.push_back(r);
        wait_idle(100, "write_req1");
        checks++;
        if (mem_log.size() != 2 || mem_log[0] !== w || mem_log[0].dataIn !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_mem_payload: count=%0d first=%h required 2 with first %h",
                     mem_log.size(), (mem_log.size() > 0) ? mem_log[0] : '0, w);
        end
        checks++;
        if (got1.size() != 1 || got1[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_rsp1: count=%0d required exactly 1 response of deadbeef", got1.size());
        end
        checks++;
        if (mem_at_rsp1 != 1) begin
            errors++;
            $display("FAIL write_no_overlap: %0d Memory requests before rsp1 completed, required 1", mem_at_rsp1);
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== patt(4)) begin
            errors++;
            $display("FAIL write_follow_read: count=%0d required 1 x %h", got0.size(), patt(4));
        end
    endtask

    task automatic test_reset_mid();
        CUtoME_IF p;
        int n;
        do_reset();
        mem_rsp_stall = 50;
        p.addrIn = 32'h0000_0010; p.dataIn = '0; p.mask = 4'hF; p.req = 1'b0;
        rq0.push_back(p);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!MemToCtl_port_sync && n < 50);
        checks++;
        if (!MemToCtl_port_sync) begin
            errors++;
            $display("FAIL midrst_reach_wait: MemToCtl sync still low after %0d cycles, required high", n);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 1'b1 || {req0_port_sync, req1_port_sync, CtlToMem_port_notify,
             MemToCtl_port_sync, rsp0_port_notify, rsp1_port_notify} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async_ctl: busy=%b grant=%b memsync=%b required 0 1 0",
                     busy, grant, MemToCtl_port_sync);
        end
        checks++;
        if (CtlToMem_port !== '0 || rsp0_port !== '0 || rsp1_port !== '0) begin
            errors++;
            $display("FAIL midrst_async_ports: ctl=%h rsp0=%h required zero", CtlToMem_port, rsp0_port);
        end
        clear_env();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mem_arr[5] = 32'h0BAD_F00D;
        p.addrIn = 32'h0000_0014;
        rq0.push_back(p);
        wait_idle(100, "midrst_after");
        checks++;
        if (got0.size() != 1 || got0[0] !== 32'h0BAD_F00D || busy_cycles != 4) begin
            errors++;
            $display("FAIL midrst_after: count=%0d busy=%0d required 1 response 0badf00d in 4 busy cycles",
                     got0.size(), busy_cycles);
        end
    endtask

    task automatic test_random();
        CUtoME_IF p;
        logic [31:0] ref0 [32];
        logic [31:0] ref1 [32];
        logic [31:0] exp0[$], exp1[$];
        int exp_order[$];
        int n0, n1, idx, last, c0, c1, w;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            ref0[i] = patt(i);
            ref1[i] = patt(32 + i);
        end
        n0 = $urandom_range(3, 8);
        n1 = $urandom_range(3, 8);
        for (int i = 0; i < n0; i++) begin
            idx = $urandom_range(0, 31);
            p.addrIn = 32'(idx * 4); p.dataIn = $urandom; p.mask = 4'hF; p.req = $urandom_range(0, 1) == 1;
            if (p.req) ref0[idx] = p.dataIn;
            exp0.push_back(ref0[idx]);
            rq0.push_back(p);
        end
        for (int i = 0; i < n1; i++) begin
            idx = $urandom_range(0, 31);
            p.addrIn = 32'((32 + idx) * 4); p.dataIn = $urandom; p.mask = 4'hF; p.req = $urandom_range(0, 1) == 1;
            if (p.req) ref1[idx] = p.dataIn;
            exp1.push_back(ref1[idx]);
            rq1.push_back(p);
        end
        last = 1; c0 = 0; c1 = 0;
        while (c0 < n0 || c1 < n1) begin
            w = next_winner(c0 < n0, c1 < n1, last);
            exp_order.push_back(w);
            last = w;
            if (w == 0) c0++; else c1++;
        end
        rand_mode = 1'b1;
        wait_idle(3000, "random");
        rand_mode = 1'b0;
        checks++;
        if (got0.size() != n0 || got1.size() != n1 || grant_log.size() != n0 + n1) begin
            errors++;
            $display("FAIL random_counts: rsp0=%0d rsp1=%0d grants=%0d required %0d %0d %0d",
                     got0.size(), got1.size(), grant_log.size(), n0, n1, n0 + n1);
        end else begin
            for (int i = 0; i < n0; i++) begin
                checks++;
                if (got0[i] !== exp0[i]) begin
                    errors++;
                    $display("FAIL random_rsp0[%0d]: %h required %h", i, got0[i], exp0[i]);
                end
            end
            for (int i = 0; i < n1; i++) begin
                checks++;
                if (got1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL random_rsp1[%0d]: %h required %h", i, got1[i], exp1[i]);
                end
            end
            for (int k = 0; k < n0 + n1; k++) begin
                checks++;
                if (grant_log[k] != exp_order[k]) begin
                    errors++;
                    $display("FAIL random_order[%0d]: grant %0d required %0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_stalls();
        test_write_req1();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
